// File: rtl/rib_arb_pkg.sv
// rib_arb_pkg: shared defaults, FSM states and master-index type
// for the rib_arbiter round-robin bus arbiter.
package rib_arb_pkg;

    localparam int DEF_NUM_M    = 4;
    localparam int DEF_MAX_HOLD = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    typedef logic [1:0] mid_t;

    function automatic logic [DEF_NUM_M-1:0] id2oh(input mid_t id);
        logic [DEF_NUM_M-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rib_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; scans requesters
// (minus an exclude mask) in circular order starting after i_last.
module rr_pick
    import rib_arb_pkg::*;
(
    input  logic [DEF_NUM_M-1:0] i_req,
    input  mid_t                 i_last,
    input  logic [DEF_NUM_M-1:0] i_excl,
    output mid_t                 o_win,
    output logic                 o_found
);

    logic [DEF_NUM_M-1:0] w_cand;
    mid_t                 w_idx;

    assign w_cand = i_req & ~i_excl;

    // k = DEF_NUM_M wraps back to i_last itself, so it is tried last
    always_comb begin
        o_win   = '0;
        o_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= DEF_NUM_M; k++) begin
            w_idx = i_last + mid_t'(k);
            if (!o_found && w_cand[w_idx]) begin
                o_win   = w_idx;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rib_arbiter.sv
// rib_arbiter: round-robin bus arbiter with bus lock. Define
// RIB_ARB_TIMEOUT_EN to enable MAX_HOLD owner preemption.
module rib_arbiter
    import rib_arb_pkg::*;
#(
    parameter int NUM_M    = DEF_NUM_M,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_M-1:0] req_i,
    output logic [NUM_M-1:0] gnt_o,
    output mid_t             gnt_id_o,
    output logic             gnt_valid_o,
    output logic [NUM_M-1:0] hold_o
);

    arb_state_t       r_state;
    arb_state_t       w_state_nx;
    logic [NUM_M-1:0] r_gnt;
    logic [NUM_M-1:0] w_gnt_nx;
    mid_t             r_id;
    mid_t             w_id_nx;
    mid_t             r_last;
    mid_t             w_last_nx;
    logic [NUM_M-1:0] w_excl;
    mid_t             w_win;
    logic             w_found;
    logic             w_new;
    logic             w_preempt;

    // the current owner never competes when the grant moves on
    assign w_excl = (r_state == OWNED) ? r_gnt : '0;

    rr_pick u_pick (
        .i_req   (req_i),
        .i_last  (r_last),
        .i_excl  (w_excl),
        .o_win   (w_win),
        .o_found (w_found)
    );

`ifdef RIB_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] r_hold;

    assign w_preempt = (r_state == OWNED) && (r_hold == HOLD_MAX)
                     && (|(req_i & ~r_gnt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_new) begin
            r_hold <= '0;
        end else if (r_state == OWNED && r_hold != HOLD_MAX) begin
            r_hold <= r_hold + 1'b1;
        end
    end
`else
    assign w_preempt = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_id_nx    = r_id;
        w_last_nx  = r_last;
        w_new      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_new = w_found;
            end
            OWNED: begin
                if (!req_i[r_id] || w_preempt) begin
                    if (w_found) begin
                        w_new = 1'b1;
                    end else begin
                        w_state_nx = IDLE;
                        w_gnt_nx   = '0;
                        w_id_nx    = '0;
                    end
                end
            end
        endcase
        if (w_new) begin
            w_state_nx = OWNED;
            w_gnt_nx   = id2oh(w_win);
            w_id_nx    = w_win;
            w_last_nx  = w_win;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_id    <= '0;
            r_last  <= mid_t'(3);
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_id    <= w_id_nx;
            r_last  <= w_last_nx;
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_id_o    = r_id;
    assign gnt_valid_o = |r_gnt;
    assign hold_o      = req_i & ~r_gnt;

endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: directed scenarios plus a random soak, checked
// each cycle against a behavioural round-robin model.
module tb_rib_arbiter;

    localparam int MH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt_o;
    logic [1:0] gnt_id_o;
    logic       gnt_valid_o;
    logic [3:0] hold_o;

    int n_pass = 0;
    int n_tot  = 0;

    int m_own  = -1;
    int m_last = 3;
    int m_held = 0;

    rib_arbiter #(.NUM_M(4), .MAX_HOLD(MH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .gnt_o       (gnt_o),
        .gnt_id_o    (gnt_id_o),
        .gnt_valid_o (gnt_valid_o),
        .hold_o      (hold_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic int pick(input logic [3:0] r, input int from,
                                input int skip);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (from + k) % 4;
            if (r[i] && i != skip) return i;
        end
        return -1;
    endfunction

    // model: owner index (-1 = idle), last winner, edges held
    initial begin : model
        int w;
        bit pre;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_own  = -1;
                m_last = 3;
                m_held = 0;
            end else begin
                w   = -1;
                pre = 1'b0;
                if (m_own < 0) begin
                    w = pick(req, m_last, -1);
                end else begin
`ifdef RIB_ARB_TIMEOUT_EN
                    pre = req[m_own] && (m_held >= MH - 1)
                        && ((req & ~(4'b0001 << m_own)) != 4'b0000);
`endif
                    if (!req[m_own] || pre) begin
                        w = pick(req, m_own, m_own);
                        if (w < 0) m_own = -1;
                    end else if (m_held < MH - 1) begin
                        m_held++;
                    end
                end
                if (w >= 0) begin
                    m_own  = w;
                    m_last = w;
                    m_held = 0;
                end
            end
        end
    end

    initial begin : compare
        logic [3:0] eg;
        forever begin
            @(negedge clk);
            eg = (m_own < 0) ? 4'b0000 : 4'(4'b0001 << m_own);
            chk("cyc_gnt", 32'(gnt_o), 32'(eg));
            chk("cyc_id", 32'(gnt_id_o), (m_own < 0) ? 0 : m_own);
            chk("cyc_valid", 32'(gnt_valid_o), 32'(m_own >= 0));
            chk("cyc_hold", 32'(hold_o), 32'(req & ~eg));
            chk("cyc_onehot", 32'($countones(gnt_o) <= 1), 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        step();
        step();
        chk("rst_gnt", 32'(gnt_o), 0);
        chk("rst_id", 32'(gnt_id_o), 0);
        chk("rst_valid", 32'(gnt_valid_o), 0);
        rst = 1'b0;
    endtask

    initial begin : stim
        do_reset();

        req = 4'b0001;
        chk("r25_lat0", 32'(gnt_o), 0);
        step();
        chk("r25_gnt", 32'(gnt_o), 32'h1);
        chk("r25_hold", 32'(hold_o), 0);
        step();
        chk("r25_hold2", 32'(hold_o), 0);

        do_reset();
        req = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            logic [3:0] e;
            e = 4'(4'b0001 << (i % 4));
            chk($sformatf("r26_own%0d_a", i), 32'(gnt_o), 32'(e));
            step();
            chk($sformatf("r26_own%0d_b", i), 32'(gnt_o), 32'(e));
            req = 4'b1111 & ~e;
            step();
            req = 4'b1111;
        end

        do_reset();
        req = 4'b0100;
        step();
        chk("r27_own2", 32'(gnt_o), 32'h4);
        req = 4'b1011;
        step();
        chk("r27_m3", 32'(gnt_o), 32'h8);
        req = 4'b0011;
        step();
        chk("r27_m0", 32'(gnt_o), 32'h1);
        req = 4'b0010;
        step();
        chk("r27_m1", 32'(gnt_o), 32'h2);
        req = 4'b0000;
        step();
        chk("r27_idle", 32'(gnt_valid_o), 0);

        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0011;
        for (int i = 0; i < MH - 1; i++) step();
        chk("r28_pre15", 32'(gnt_o), 32'h1);
        step();
`ifdef RIB_ARB_TIMEOUT_EN
        chk("r28_at16", 32'(gnt_o), 32'h2);
`else
        chk("r28_at16", 32'(gnt_o), 32'h1);
        for (int i = 0; i < 20; i++) step();
        chk("r28_never", 32'(gnt_o), 32'h1);
`endif

        do_reset();
        req = 4'b0010;
        step();
        chk("r29_gnt1", 32'(gnt_o), 32'h2);
        #1 rst = 1'b1;
        #1;
        chk("r29_async_gnt", 32'(gnt_o), 0);
        chk("r29_async_valid", 32'(gnt_valid_o), 0);
        req = 4'b0110;
        @(negedge clk);
        #1 rst = 1'b0;
        step();
        chk("r29_regrant", 32'(gnt_o), 32'h2);
        chk("r29_id", 32'(gnt_id_o), 1);

        do_reset();
        for (int i = 0; i < 10000; i++) begin
            req = 4'($urandom_range(0, 15));
            step();
        end

        req = 4'b0000;
        step();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
